// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Definitions shared by the up-counter blocks and countdown_timer.
//   state_e      : timer state encoding (IDLE=0, RUN=1, PAUSE=2, DONE=3),
//                  the same value that appears on o_state
//   DEF_CNT_W    : default count width
//   DEF_MAX_VAL  : default largest legal count
// -----------------------------------------------------------------------------
package counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int DEF_CNT_W   = 7;
   localparam int DEF_MAX_VAL = 99;

endpackage : counter_pkg

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides the clock into a one-cycle tick every PRESCALE enabled cycles.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   en      : advance the phase counter this cycle (holds when low)
//   clr     : force the phase counter back to 0 (wins over en)
//   tick    : high on an enabled cycle whose phase is PRESCALE-1
// -----------------------------------------------------------------------------
module tick_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   // At least one bit so PRESCALE=1 still elaborates; the counter then
   // simply stays at 0 and every enabled cycle is a tick.
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0] phase_q;
   logic [PW-1:0] phase_d;
   logic          wrap;

   assign wrap = (phase_q == PW'(PRESCALE - 1));
   assign tick = en && wrap;

   always_comb begin
      phase_d = phase_q;
      if (clr) begin
         phase_d = '0;
      end else if (en) begin
         phase_d = wrap ? '0 : phase_q + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

endmodule : tick_prescaler

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
// Loadable down-counter. A start value is loaded, decremented once per
// prescaled tick in RUN, and on reaching zero a one-cycle done pulse is
// produced; the timer then stops in DONE or reloads and keeps running.
//   clk, reset_n : clock, asynchronous active-low reset
//   i_load       : load i_load_val (saturated to MAX_VAL) into count and
//                  reload register, go IDLE (highest priority)
//   i_load_val   : value to load
//   i_start      : start from IDLE, resume from PAUSE, restart from DONE
//   i_pause      : freeze the count while in RUN
//   i_reload_en  : reload and keep running when the count reaches zero
//   o_cnt        : current count
//   o_busy       : high in RUN only
//   o_done       : one-cycle pulse on the first cycle the count shows zero
//   o_state      : IDLE=0, RUN=1, PAUSE=2, DONE=3
// -----------------------------------------------------------------------------
module countdown_timer
   import counter_pkg::*;
#(
   parameter int CNT_W    = DEF_CNT_W,
   parameter int MAX_VAL  = DEF_MAX_VAL,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_start,
   input  logic             i_pause,
   input  logic             i_reload_en,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_busy,
   output logic             o_done,
   output logic [1:0]       o_state
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_VAL);

   state_e           state_q,  state_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [CNT_W-1:0] reload_q, reload_d;
   logic             done_q,   done_d;
   // Set when the count has just reached zero with reload enabled: the
   // next tick reloads instead of treating the zero as a fresh expiry.
   logic             pend_q,   pend_d;

   logic [CNT_W-1:0] load_sat;
   logic             pre_en;
   logic             pre_clr;
   logic             tick;

   assign load_sat = (i_load_val > MAX_CNT) ? MAX_CNT : i_load_val;

   // The prescaler only advances on cycles where RUN actually counts; a
   // pause request in RUN freezes it in the same cycle.
   assign pre_en  = (state_q == ST_RUN) && !i_load && !i_pause;
   assign pre_clr = i_load ||
                    (i_start && ((state_q == ST_IDLE) || (state_q == ST_DONE)));

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (pre_en),
      .clr     (pre_clr),
      .tick    (tick)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      reload_d = reload_q;
      done_d   = 1'b0;
      pend_d   = pend_q;

      if (i_load) begin
         cnt_d    = load_sat;
         reload_d = load_sat;
         state_d  = ST_IDLE;
         pend_d   = 1'b0;
      end else if (i_start && (state_q != ST_RUN)) begin
         state_d = ST_RUN;
         if (state_q == ST_DONE) begin
            cnt_d  = reload_q;
            pend_d = 1'b0;
         end
      end else if (i_pause && (state_q == ST_RUN)) begin
         state_d = ST_PAUSE;
      end else if ((state_q == ST_RUN) && tick) begin
         if (cnt_q > CNT_W'(1)) begin
            cnt_d = cnt_q - CNT_W'(1);
         end else if (cnt_q == CNT_W'(1)) begin
            cnt_d  = '0;
            done_d = 1'b1;
            if (i_reload_en && (reload_q != '0)) begin
               pend_d = 1'b1;
            end else begin
               state_d = ST_DONE;
            end
         end else if (pend_q) begin
            // Zero was shown for one tick period; start the next interval.
            cnt_d  = reload_q;
            pend_d = 1'b0;
         end else begin
            // Entered RUN with a zero count: expire without underflowing.
            done_d  = 1'b1;
            state_d = ST_DONE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         reload_q <= '0;
         done_q   <= 1'b0;
         pend_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         reload_q <= reload_d;
         done_q   <= done_d;
         pend_q   <= pend_d;
      end
   end

   assign o_cnt   = cnt_q;
   assign o_done  = done_q;
   assign o_state = state_q;
   assign o_busy  = (state_q == ST_RUN);

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
// Two timers (PRESCALE=1 and PRESCALE=4) share one stimulus stream and are
// compared every cycle against a behavioural model of the timer rules.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

   localparam int CW = 7;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          i_load = 1'b0;
   logic [CW-1:0] i_load_val = '0;
   logic          i_start = 1'b0;
   logic          i_pause = 1'b0;
   logic          i_reload_en = 1'b0;

   logic [CW-1:0] cnt1, cnt4;
   logic          busy1, busy4, done1, done4;
   logic [1:0]    st1, st4;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   countdown_timer #(.CNT_W(CW), .MAX_VAL(99), .PRESCALE(1)) dut1 (
      .clk (clk), .reset_n (reset_n), .i_load (i_load), .i_load_val (i_load_val),
      .i_start (i_start), .i_pause (i_pause), .i_reload_en (i_reload_en),
      .o_cnt (cnt1), .o_busy (busy1), .o_done (done1), .o_state (st1));

   countdown_timer #(.CNT_W(CW), .MAX_VAL(99), .PRESCALE(4)) dut4 (
      .clk (clk), .reset_n (reset_n), .i_load (i_load), .i_load_val (i_load_val),
      .i_start (i_start), .i_pause (i_pause), .i_reload_en (i_reload_en),
      .o_cnt (cnt4), .o_busy (busy4), .o_done (done4), .o_state (st4));

   // Model: mode 0 idle, 1 running, 2 paused, 3 expired.
   // 'ph' is how many counting clocks of the current tick period have elapsed;
   // 'zero_hold' marks the one tick period a reloading timer shows zero.
   typedef struct {
      int mode;
      int cnt;
      int rel;
      int ph;
      bit zero_hold;
      bit done;
   } mdl_t;

   mdl_t m1, m4;

   function automatic mdl_t mdl_reset();
      mdl_t r;
      r.mode = 0; r.cnt = 0; r.rel = 0; r.ph = 0; r.zero_hold = 0; r.done = 0;
      return r;
   endfunction

   function automatic mdl_t mdl_step(mdl_t m, int presc, bit ld, int lv,
                                     bit st, bit pa, bit re);
      mdl_t n;
      n = m;
      n.done = 0;
      if (ld) begin
         n.cnt = (lv > 99) ? 99 : lv;
         n.rel = n.cnt;
         n.mode = 0;
         n.ph = 0;
         n.zero_hold = 0;
      end else if (st && m.mode != 1) begin
         n.mode = 1;
         if (m.mode != 2) n.ph = 0;
         if (m.mode == 3) begin
            n.cnt = m.rel;
            n.zero_hold = 0;
         end
      end else if (pa && m.mode == 1) begin
         n.mode = 2;
      end else if (m.mode == 1) begin
         n.ph = m.ph + 1;
         if (n.ph == presc) begin
            n.ph = 0;
            if (m.cnt >= 2) begin
               n.cnt = m.cnt - 1;
            end else if (m.cnt == 1) begin
               n.cnt = 0;
               n.done = 1;
               if (re && m.rel != 0) n.zero_hold = 1;
               else n.mode = 3;
            end else if (m.zero_hold) begin
               n.cnt = m.rel;
               n.zero_hold = 0;
            end else begin
               n.done = 1;
               n.mode = 3;
            end
         end
      end
      return n;
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      check("p1.cnt",   int'(cnt1),  m1.cnt);
      check("p1.state", int'(st1),   m1.mode);
      check("p1.busy",  int'(busy1), (m1.mode == 1) ? 1 : 0);
      check("p1.done",  int'(done1), int'(m1.done));
      check("p4.cnt",   int'(cnt4),  m4.cnt);
      check("p4.state", int'(st4),   m4.mode);
      check("p4.busy",  int'(busy4), (m4.mode == 1) ? 1 : 0);
      check("p4.done",  int'(done4), int'(m4.done));
   endtask

   // One clock: inputs are held across the rising edge, the model steps with
   // the same inputs, and outputs are compared on the falling edge.
   task automatic step(input bit ld, input int lv, input bit st, input bit pa);
      i_load = ld;
      i_load_val = CW'(lv);
      i_start = st;
      i_pause = pa;
      @(posedge clk);
      m1 = mdl_step(m1, 1, ld, lv, st, pa, i_reload_en);
      m4 = mdl_step(m4, 4, ld, lv, st, pa, i_reload_en);
      @(negedge clk);
      check_all();
      i_load = 1'b0;
      i_start = 1'b0;
      i_pause = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0);
   endtask

   initial begin
      int guard;
      int lv;
      bit ld, st, pa;

      m1 = mdl_reset();
      m4 = mdl_reset();
      @(negedge clk);
      @(negedge clk);
      check_all();
      reset_n = 1'b1;
      idle_cycles(2);

      // Load 5, run to zero without reload.
      $display("txn: load 5, start, reload off");
      step(1, 5, 0, 0);
      step(0, 0, 1, 0);
      idle_cycles(8);
      check("p1.done_state", int'(st1), 3);
      idle_cycles(16);

      // Saturating load, then start.
      $display("txn: load 120 (saturates)");
      step(1, 120, 0, 0);
      check("sat.cnt", int'(cnt1), 99);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      check("sat.first_dec", int'(cnt1), 98);

      // Load 3 with a pause/resume in the middle.
      $display("txn: load 3, start, pause, resume");
      step(1, 3, 0, 0);
      step(0, 0, 1, 0);
      idle_cycles(5);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      step(0, 0, 1, 1);
      idle_cycles(14);

      // Auto reload of 2.
      $display("txn: load 2, start, reload on");
      i_reload_en = 1'b1;
      step(1, 2, 0, 0);
      step(0, 0, 1, 0);
      idle_cycles(12);
      check("rel.state", int'(st1), 1);
      i_reload_en = 1'b0;

      // Zero load, start, then restart from DONE.
      $display("txn: load 0, start, restart");
      step(1, 0, 0, 0);
      step(0, 0, 1, 0);
      idle_cycles(6);
      step(0, 0, 1, 0);
      idle_cycles(6);

      // Reset mid-count at o_cnt=40.
      $display("txn: async reset at count 40");
      step(1, 50, 0, 0);
      step(0, 0, 1, 0);
      guard = 0;
      while (m1.cnt != 40 && guard < 100) begin
         step(0, 0, 0, 0);
         guard++;
      end
      check("rst.reach40", int'(cnt1), 40);
      #1 reset_n = 1'b0;
      #1;
      m1 = mdl_reset();
      m4 = mdl_reset();
      check_all();
      @(negedge clk);
      check_all();
      reset_n = 1'b1;
      idle_cycles(2);

      // Load coinciding with the 1->0 tick.
      $display("txn: load collides with zero event");
      step(1, 1, 0, 0);
      step(0, 0, 1, 0);
      step(1, 7, 0, 0);
      check("col.done", int'(done1), 0);
      check("col.cnt", int'(cnt1), 7);

      // Randomized traffic.
      $display("txn: random traffic");
      for (int c = 0; c < 3000; c++) begin
         ld = ($urandom_range(0, 39) == 0);
         st = ($urandom_range(0, 5) == 0);
         pa = ($urandom_range(0, 9) == 0);
         lv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127))
                                          : int'($urandom_range(0, 6));
         if ($urandom_range(0, 49) == 0) i_reload_en = ~i_reload_en;
         step(ld, lv, st, pa);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_countdown_timer

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter/timer; the count-down counterpart of the team's 0..99 up-counters.
- A start value (0..MAX_VAL) is loaded and decremented once per prescaled tick.
- On reaching zero it emits a one-cycle done pulse, then either stops or auto-reloads.
- Used as a general delay/interval source next to the up-counter blocks.

Parameters:
- CNT_W, 7, width of count, load value and reload register.
- MAX_VAL, 99, largest legal count; larger load values saturate to MAX_VAL.
- PRESCALE, 1, clocks per decrement tick (>=1); PRESCALE=1 means decrement every clock in RUN.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- i_load  input  1  load i_load_val into count and reload register; go IDLE.
- i_load_val  input  CNT_W  value to load (saturated to MAX_VAL).
- i_start  input  1  start from IDLE, resume from PAUSE, restart from DONE.
- i_pause  input  1  freeze count while in RUN.
- i_reload_en  input  1  when 1, reaching zero reloads and keeps running.
- o_cnt  output  CNT_W  current count.
- o_busy  output  1  high in RUN only.
- o_done  output  1  one-cycle pulse when count reaches zero.
- o_state  output  2  state encoding: IDLE=0, RUN=1, PAUSE=2, DONE=3.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, o_cnt=0, reload_reg=0, prescaler=0, o_done=0, o_busy=0.
  - Reset mid-count aborts immediately; no done pulse is produced.
- All outputs are registered; o_busy is decoded from the state register.
- Priority each cycle: i_load > i_start > i_pause.
- i_load (any state):
  - o_cnt and reload_reg take min(i_load_val, MAX_VAL).
  - state=IDLE, prescaler=0, o_done=0 next cycle.
- i_start:
  - IDLE: RUN, prescaler=0.
  - PAUSE: RUN; prescaler keeps its held value.
  - DONE: o_cnt=reload_reg, RUN, prescaler=0.
  - RUN: ignored.
- i_pause:
  - RUN: PAUSE; o_cnt and prescaler hold.
  - Other states: ignored.
  - i_start+i_pause together in PAUSE resumes (start wins); together in RUN pauses (start is ignored in RUN).
- Tick: in RUN the prescaler counts 0..PRESCALE-1 and wraps. tick=1 on the cycle the prescaler equals PRESCALE-1. For PRESCALE=1, tick=1 every RUN cycle.
- On tick in RUN:
  - o_cnt>1: o_cnt decrements by 1.
  - o_cnt==1: o_cnt=0, o_done=1 on the next cycle, coincident with the first cycle o_cnt==0. Then:
    - i_reload_en=0 or reload_reg==0: state=DONE.
    - otherwise: next tick loads reload_reg and the state stays RUN. o_cnt shows 0 for exactly one tick period, so the reload period is reload_reg+1 ticks.
- Entering RUN with o_cnt==0 (start after load of 0): first tick gives o_done pulse and state=DONE; no underflow.
- o_cnt never underflows below 0 and never exceeds MAX_VAL.
- o_done is high for exactly one clock per zero event, and is 0 in all other cycles.
- i_reload_en is sampled on the tick where o_cnt goes 1->0.
- i_load in the same cycle as a zero event: the load wins and o_done is suppressed.
- DONE holds o_cnt=0 until i_load or i_start.

Decomposition:
- Shared package (counter_pkg):
  - state encoding localparams ST_IDLE/ST_RUN/ST_PAUSE/ST_DONE.
  - default CNT_W/MAX_VAL constants, shared with the up-counter blocks.
- One natural sub-module: tick_prescaler (parameter PRESCALE; inputs clk, reset_n, en, clr; output tick).
- FSM, count register and done logic stay in countdown_timer.

Test Plan:
- PRESCALE=1: load 5, start, reload_en=0 -> o_cnt 5,4,3,2,1,0 on consecutive clocks; o_done high only in the first cycle o_cnt=0; o_state=3; o_busy=0 afterwards.
- Load 120 (above MAX_VAL=99) -> o_cnt=99 next cycle; start -> 98 after one clock.
- PRESCALE=4: load 3, start -> each value held 4 clocks; o_done 12 clocks after RUN entry. Pause 2 clocks at o_cnt=2, then resume -> total extended by exactly 2 clocks.
- reload_en=1, load 2, start -> o_cnt 2,1,0,2,1,0,...; o_done every 3 clocks; state stays RUN.
- Load 0, start -> one o_done pulse, DONE, o_cnt stays 0. Start again from DONE -> immediate DONE again with one pulse.
- Assert reset_n=0 mid-count at o_cnt=40 -> o_cnt=0, IDLE, no o_done. Load in the same cycle as the 1->0 tick -> new value loaded, no o_done.
